sha256_msg_padder: RTL

Parametrised multi-block SHA-256 message padder. On a start pulse it streams an L-byte message out of a byte-wide synchronous SRAM, appends the 0x80 marker, zero fill and the 64-bit big-endian bit length, and emits the result as a sequence of 512-bit blocks. Each block is handed over on a valid/ready handshake. The block sits between the message SRAM and the SHA-256 compression core, and lifts the single-block 55-byte limit of the earlier padder.

---
 rtl/sha256_pad_pkg.sv | 18 +
 rtl/sha256_pad_byte_sel.sv | 46 ++++
 rtl/sha256_msg_padder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pad_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sha256_pad_pkg;

    localparam int          BLOCK_BITS      = 512;
    localparam int          BLOCK_BYTES     = 64;
    localparam int          LEN_FIELD_BYTES = 8;
    localparam logic [7:0]  PAD_MARKER      = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } pad_state_t;

endpackage

// File: rtl/sha256_pad_byte_sel.sv
// Chooses the padded byte value for one global byte index of the message stream.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is written.
//
// Ports:
//   g            global byte index (64*block + position)
//   p            byte position inside the current block, 0..63
//   len          message length L in bytes
//   is_last      the current block is the final block
//   mem_data     SRAM byte returned for index g (only meaningful when g < L)
//   byte_dat     byte to store at position p
import sha256_pad_pkg::*;

module sha256_pad_byte_sel #(
    parameter int ADDR_WIDTH = 10,
    parameter int G_WIDTH    = 11
) (
    input  logic [G_WIDTH-1:0]    g,
    input  logic [5:0]            p,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  is_last,
    input  logic [7:0]            mem_data,
    output logic [7:0]            byte_dat
);

    logic [G_WIDTH-1:0] len_ext;
    logic [63:0]        bit_len;
    logic [5:0]         rev_pos;

    assign len_ext = G_WIDTH'(len);
    assign bit_len = 64'(len) << 3;
    // Position 63 carries the least significant byte of the bit length.
    assign rev_pos = 6'd63 - p;

    always_comb begin
        byte_dat = 8'h00;
        if (g < len_ext) begin
            byte_dat = mem_data;
        end else if (g == len_ext) begin
            byte_dat = PAD_MARKER;
        end else if (is_last && (p >= 6'(BLOCK_BYTES - LEN_FIELD_BYTES))) begin
            byte_dat = 8'(bit_len >> {rev_pos, 3'b000});
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams an L-byte message from a byte SRAM and emits SHA-256 padded 512-bit blocks.
// Latency: first block valid 66 cycles after go_sig, each later block 65 cycles after its predecessor's handshake.
// Backpressure: blk_ready low holds the block in HOLD indefinitely with no SRAM reads issued.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   go_sig, msg_len       start pulse (IDLE only) and message length in bytes
//   msg_mem_en/addr/data  byte SRAM read port, one cycle read latency
//   blk_data/valid/ready  padded block handshake, byte 0 in [511:504]
//   blk_last              qualifies blk_valid, marks the final block
//   pad_done              single-cycle pulse after the final handshake
//   len_err               (only with SHA_PAD_LEN_CHECK_EN) out-of-range length pulse
//
// Optional feature macro: SHA_PAD_LEN_CHECK_EN
import sha256_pad_pkg::*;

module sha256_msg_padder #(
    parameter int MAX_MESSAGE_LENGTH = 1023,
    parameter int ADDR_WIDTH         = $clog2(MAX_MESSAGE_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go_sig,
    input  logic [ADDR_WIDTH-1:0] msg_len,
    input  logic [7:0]            msg_mem_data,
    output logic                  msg_mem_en,
    output logic [ADDR_WIDTH-1:0] msg_mem_addr,
    output logic [BLOCK_BITS-1:0] blk_data,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  blk_last,
    output logic                  pad_done
`ifdef SHA_PAD_LEN_CHECK_EN
    ,
    output logic                  len_err
`endif
);

    // Block index must hold N-1 = floor((MAX+8)/64) at the largest length.
    localparam int BLK_RAW = $clog2((MAX_MESSAGE_LENGTH + LEN_FIELD_BYTES) / BLOCK_BYTES + 1);
    localparam int BLK_W   = (BLK_RAW < 1) ? 1 : BLK_RAW;
    localparam int G_W     = BLK_W + 6;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_FILL = FILL;
    localparam logic [1:0] S_HOLD = HOLD;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [BLK_W-1:0]      blk_idx;
    logic [6:0]            rd_p;      // next position to issue, 64 = all issued
    logic [5:0]            wr_p;      // next position to write
    logic                  iss_q;     // a read slot was issued last cycle
    logic                  wr_vld;    // SRAM data for position wr_p is present now

    logic [G_W-1:0]        len_ext;
    logic [G_W-1:0]        len_p8;
    logic [G_W-1:0]        g_rd;
    logic [G_W-1:0]        g_next;
    logic [G_W-1:0]        g_wr;
    logic                  is_last;
    logic [7:0]            sel_byte;

    assign len_ext = G_W'(len_q);
    assign len_p8  = len_ext + G_W'(LEN_FIELD_BYTES);
    // Final block index is floor((L+8)/64).
    assign is_last = ((len_p8 >> 6) == G_W'(blk_idx));
    assign g_rd    = {blk_idx, rd_p[5:0]};
    assign g_next  = {blk_idx + BLK_W'(1), 6'd0};
    assign g_wr    = {blk_idx, wr_p};

    sha256_pad_byte_sel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .G_WIDTH    (G_W)
    ) u_byte_sel (
        .g        (g_wr),
        .p        (wr_p),
        .len      (len_q),
        .is_last  (is_last),
        .mem_data (msg_mem_data),
        .byte_dat (sel_byte)
    );

    assign blk_valid = (state_q == S_HOLD);
    assign blk_last  = (state_q == S_HOLD) && is_last;
    assign pad_done  = (state_q == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            blk_idx      <= '0;
            rd_p         <= '0;
            wr_p         <= '0;
            iss_q        <= 1'b0;
            wr_vld       <= 1'b0;
            msg_mem_en   <= 1'b0;
            msg_mem_addr <= '0;
            blk_data     <= '0;
`ifdef SHA_PAD_LEN_CHECK_EN
            len_err      <= 1'b0;
`endif
        end else begin
            // Every issue slot (real read or not) yields exactly one write two edges later.
            msg_mem_en <= 1'b0;
            iss_q      <= 1'b0;
            wr_vld     <= iss_q;
`ifdef SHA_PAD_LEN_CHECK_EN
            len_err    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (go_sig) begin
`ifdef SHA_PAD_LEN_CHECK_EN
                        if ({1'b0, msg_len} > (ADDR_WIDTH + 1)'(MAX_MESSAGE_LENGTH)) begin
                            len_err <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                        end
`else
                        state_q <= S_FILL;
`endif
                        len_q   <= msg_len;
                        blk_idx <= '0;
                        rd_p    <= '0;
                        wr_p    <= '0;
                    end
                end
                S_FILL: begin
                    if (rd_p < 7'd64) begin
                        iss_q <= 1'b1;
                        rd_p  <= rd_p + 7'd1;
                        if (g_rd < len_ext) begin
                            msg_mem_en   <= 1'b1;
                            msg_mem_addr <= ADDR_WIDTH'(g_rd);
                        end
                    end
                    if (wr_vld) begin
                        blk_data[BLOCK_BITS - 8 - 8 * int'(wr_p) +: 8] <= sel_byte;
                        wr_p <= wr_p + 6'd1;
                        if (wr_p == 6'd63) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (blk_ready) begin
                        if (is_last) begin
                            state_q <= S_DONE;
                        end else begin
                            // Issue position 0 of the next block on the handshake edge
                            // so the next block completes 65 cycles later.
                            state_q <= S_FILL;
                            blk_idx <= blk_idx + BLK_W'(1);
                            rd_p    <= 7'd1;
                            iss_q   <= 1'b1;
                            if (g_next < len_ext) begin
                                msg_mem_en   <= 1'b1;
                                msg_mem_addr <= ADDR_WIDTH'(g_next);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
